program_loader: RTL

// Byte-stream boot controller that sequences the CPU's program download port. It parses a framed

---
 rtl/program_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (sync, length, 16-bit words, XOR checksum),
// drives the instruction-cache download port and releases the CPU only after a clean frame.
module program_loader #(
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    localparam int          TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

    state_t               state_q, state_d;
    logic [7:0]           acc_q, acc_d;
    logic [7:0]           lo_q, lo_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          words_q, words_d;
    logic [31:0]          index_q, index_d;
    logic [15:0]          prog_q, prog_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic                 in_frame;
    logic [15:0]          len_full;

    assign in_frame = (state_q == S_LEN_LO)  || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_CHK);
    assign len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        len_d   = len_q;
        words_d = words_q;
        index_d = index_q;
        prog_d  = prog_q;

        if (!in_frame || rx_valid) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // The timeout wins over a byte arriving on the very cycle the limit is reached.
        if (in_frame && (timer_q == TIMER_LIMIT)) begin
            state_d = S_ERR;
            timer_d = '0;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE, S_RUN, S_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_LEN_LO;
                        acc_d   = '0;
                        words_d = '0;
                        index_d = '0;
                    end
                end
                S_LEN_LO: begin
                    len_d[7:0] = rx_data;
                    acc_d      = acc_q ^ rx_data;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d[15:8] = rx_data;
                    acc_d       = acc_q ^ rx_data;
                    if ({1'b0, len_full} > MAX_N) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    lo_d    = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_DATA_HI;
                end
                S_DATA_HI: begin
                    // Index and data move on the same edge so the cache never sees a torn pair.
                    prog_d  = {rx_data, lo_q};
                    index_d = {16'd0, words_q};
                    words_d = words_q + 16'd1;
                    acc_d   = acc_q ^ rx_data;
                    if ((words_q + 16'd1) == len_q) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
                S_CHK: begin
                    state_d = (rx_data == acc_q) ? S_RUN : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            lo_q    <= '0;
            len_q   <= '0;
            words_q <= '0;
            index_q <= '0;
            prog_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            len_q   <= len_d;
            words_q <= words_d;
            index_q <= index_d;
            prog_q  <= prog_d;
            timer_q <= timer_d;
        end
    end

    // The CPU runs only in RUN; every other state keeps it halted with the write port open.
    assign download_program  = (state_q != S_RUN);
    assign busy              = in_frame;
    assign load_done         = (state_q == S_RUN);
    assign load_error        = (state_q == S_ERR);
    assign instruction_index = index_q;
    assign program_in        = prog_q;
    assign words_loaded      = words_q;

endmodule
